// File: rtl/uart_frame_rx.sv
// Command-frame reader: hunts for SYNC, shifts in payload chars, checks the XOR checksum,
// enforces inter-character timeout and hands one command word per good frame over valid/ready.
module uart_frame_rx #(
    parameter int unsigned     BITS       = 8,
    parameter int unsigned     WORD_CHARS = 4,
    parameter logic [BITS-1:0] SYNC       = 8'hA5,
    parameter int unsigned     TIMEOUT    = 50000,
    parameter int unsigned     TO_WIDTH   = $clog2(TIMEOUT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BITS-1:0]            rx_data,
    input  logic                       rx_data_fresh,
    output logic [BITS*WORD_CHARS-1:0] cmd_word,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic                       chk_err,
    output logic                       timeout_err,
    output logic                       overrun_err
);

    localparam int unsigned W    = BITS * WORD_CHARS;
    localparam int unsigned IdxW = (WORD_CHARS > 1) ? $clog2(WORD_CHARS) : 1;

    localparam logic [IdxW-1:0]     IdxLast = IdxW'(WORD_CHARS - 1);
    localparam logic [TO_WIDTH-1:0] ToLast  = TO_WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StHunt,
        StPayload,
        StCheck
    } state_e;

    state_e              state_q;
    logic [IdxW-1:0]     idx_q;
    logic [BITS-1:0]     acc_q;
    logic [W-1:0]        shadow_q;
    logic [TO_WIDTH-1:0] to_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StHunt;
            idx_q       <= '0;
            acc_q       <= '0;
            shadow_q    <= '0;
            to_cnt_q    <= '0;
            cmd_word    <= '0;
            cmd_valid   <= 1'b0;
            chk_err     <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            chk_err     <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;

            // Consumer transfer; a reload in the CHECK branch below overrides this clear.
            if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end

            unique case (state_q)
                StHunt: begin
                    to_cnt_q <= '0;
                    if (rx_data_fresh && rx_data == SYNC) begin
                        state_q <= StPayload;
                        idx_q   <= '0;
                        acc_q   <= '0;
                    end
                end

                StPayload: begin
                    if (rx_data_fresh) begin
                        to_cnt_q <= '0;
                        shadow_q <= (shadow_q << BITS) | W'(rx_data);
                        acc_q    <= acc_q ^ rx_data;
                        idx_q    <= idx_q + 1'b1;
                        if (idx_q == IdxLast) begin
                            state_q <= StCheck;
                        end
                    end else if (to_cnt_q == ToLast) begin
                        state_q     <= StHunt;
                        timeout_err <= 1'b1;
                        to_cnt_q    <= '0;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end

                StCheck: begin
                    if (rx_data_fresh) begin
                        state_q  <= StHunt;
                        to_cnt_q <= '0;
                        if (rx_data == acc_q) begin
                            if (!cmd_valid || cmd_ready) begin
                                cmd_word  <= shadow_q;
                                cmd_valid <= 1'b1;
                            end else begin
                                overrun_err <= 1'b1;
                            end
                        end else begin
                            chk_err <= 1'b1;
                        end
                    end else if (to_cnt_q == ToLast) begin
                        state_q     <= StHunt;
                        timeout_err <= 1'b1;
                        to_cnt_q    <= '0;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end

                default: state_q <= StHunt;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: good/bad frames, garbage, timeout, backpressure, reset.
module tb_uart_frame_rx;

    localparam int unsigned TO = 20;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_data_fresh;
    logic [31:0] cmd_word;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        chk_err;
    logic        timeout_err;
    logic        overrun_err;

    int checks = 0;
    int errors = 0;

    uart_frame_rx #(
        .BITS       (8),
        .WORD_CHARS (4),
        .SYNC       (8'hA5),
        .TIMEOUT    (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_data_fresh (rx_data_fresh),
        .cmd_word      (cmd_word),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .chk_err       (chk_err),
        .timeout_err   (timeout_err),
        .overrun_err   (overrun_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; strobes one char for exactly one posedge.
    task automatic send(input logic [7:0] c);
        rx_data       = c;
        rx_data_fresh = 1'b1;
        @(negedge clk);
        rx_data_fresh = 1'b0;
    endtask

    task automatic send_payload(input logic [31:0] w);
        send(8'hA5);
        for (int i = 0; i < 4; i++) send(w[31-8*i -: 8]);
    endtask

    task automatic check_errs(input string tag, input logic [2:0] exp);
        check(tag, {29'd0, chk_err, timeout_err, overrun_err}, {29'd0, exp});
    endtask

    task automatic consume();
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
    endtask

    initial begin
        rst           = 1'b0;
        rx_data       = 8'h00;
        rx_data_fresh = 1'b0;
        cmd_ready     = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_valid", {31'd0, cmd_valid}, 32'd0);
        check("reset_word", cmd_word, 32'd0);
        check_errs("reset_errs", 3'b000);
        rst = 1'b1;
        @(negedge clk);

        // 1. good frame, held until accepted
        send_payload(32'h12345678);
        send(8'h08);
        check("t1_valid", {31'd0, cmd_valid}, 32'd1);
        check("t1_word", cmd_word, 32'h12345678);
        check_errs("t1_errs", 3'b000);
        repeat (3) @(negedge clk);
        check("t1_hold_valid", {31'd0, cmd_valid}, 32'd1);
        check("t1_hold_word", cmd_word, 32'h12345678);
        consume();
        check("t1_consumed", {31'd0, cmd_valid}, 32'd0);

        // 2. bad checksum then good frame
        send_payload(32'h12345678);
        send(8'h09);
        check_errs("t2_chk_pulse", 3'b100);
        check("t2_no_valid", {31'd0, cmd_valid}, 32'd0);
        @(negedge clk);
        check_errs("t2_chk_cleared", 3'b000);
        send_payload(32'h12345678);
        send(8'h08);
        check("t2_next_valid", {31'd0, cmd_valid}, 32'd1);
        check("t2_next_word", cmd_word, 32'h12345678);
        consume();

        // 3. garbage and SYNC-valued payload chars
        send(8'h00);
        send(8'hFF);
        send_payload(32'hA5000001);
        send(8'hA4);
        check("t3_valid", {31'd0, cmd_valid}, 32'd1);
        check("t3_word", cmd_word, 32'hA5000001);
        check_errs("t3_errs", 3'b000);
        consume();

        // 4a. stall after A5 12: timeout fires on the TO-th idle cycle
        send(8'hA5);
        send(8'h12);
        repeat (TO - 1) @(negedge clk);
        check_errs("t4_before_expiry", 3'b000);
        @(negedge clk);
        check_errs("t4_timeout_pulse", 3'b010);
        @(negedge clk);
        check_errs("t4_timeout_cleared", 3'b000);
        send_payload(32'hDEADBEEF);
        send(8'h22);
        check("t4_valid", {31'd0, cmd_valid}, 32'd1);
        check("t4_word", cmd_word, 32'hDEADBEEF);
        consume();

        // 4b. strobe landing in the expiry cycle wins over the timeout
        send(8'hA5);
        repeat (TO - 1) @(negedge clk);
        send(8'h12);
        check_errs("t4_strobe_wins", 3'b000);
        send(8'h34);
        send(8'h56);
        send(8'h78);
        send(8'h08);
        check("t4b_valid", {31'd0, cmd_valid}, 32'd1);
        check("t4b_word", cmd_word, 32'h12345678);
        consume();

        // 5. backpressure: overrun, then back-to-back reload
        send_payload(32'h12345678);
        send(8'h08);
        check("t5_first_word", cmd_word, 32'h12345678);
        send_payload(32'hDEADBEEF);
        send(8'h22);
        check_errs("t5_overrun_pulse", 3'b001);
        check("t5_kept_word", cmd_word, 32'h12345678);
        check("t5_kept_valid", {31'd0, cmd_valid}, 32'd1);
        @(negedge clk);
        check_errs("t5_overrun_cleared", 3'b000);
        send_payload(32'hDEADBEEF);
        cmd_ready = 1'b1;
        send(8'h22);
        cmd_ready = 1'b0;
        check("t5_reload_valid", {31'd0, cmd_valid}, 32'd1);
        check("t5_reload_word", cmd_word, 32'hDEADBEEF);
        check_errs("t5_reload_errs", 3'b000);

        // 6. async reset mid-frame with a command pending
        send(8'hA5);
        send(8'h12);
        send(8'h34);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_valid", {31'd0, cmd_valid}, 32'd0);
        check("t6_rst_word", cmd_word, 32'd0);
        check_errs("t6_rst_errs", 3'b000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send_payload(32'h12345678);
        send(8'h08);
        check("t6_valid", {31'd0, cmd_valid}, 32'd1);
        check("t6_word", cmd_word, 32'h12345678);
        check_errs("t6_errs", 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
